queue_motion_ctrl: RTL and testbench
====================================

// Module: queue_motion_ctrl
// PURPOSE
//   Per-frame motion/state sequencer for the 44x50 "queue" player sprite. Turns button inputs into the
//   registered posX/posY, play state and facing (animation_state) consumed by the sprite renderer.
//   Runs on the pixel clock; all updates are gated by a one-cycle frame_tick from the VGA timing block.
// PARAMETERS
//   START_X   100  spawn X (sprite centre) in INITIAL and after game_over
//   GROUND_Y  400  floor Y (sprite centre); screen Y grows downward
//   X_MIN      22  left clamp (half sprite width)
//   X_MAX     617  right clamp (640-1-22)
//   Y_MIN      25  ceiling clamp (half sprite height)
//   SPEED_X     2  pixels per frame horizontal
//   JUMP_V     12  initial upward speed, px/frame
//   GRAVITY     1  vy increment per frame
//   MAX_FALL   12  max downward vy
// PORTS
//   clk              in   1   pixel clock
//   rst_n            in   1   synchronous, active-low reset
//   frame_tick       in   1   one-cycle pulse per frame (start of vblank)
//   btn_start        in   1   raw button, async
//   btn_left         in   1   raw button, async
//   btn_right        in   1   raw button, async
//   btn_jump         in   1   raw button, async
//   game_over        in   1   level pulse from collision logic, sync to clk
//   posX             out  10  sprite centre X
//   posY             out  9   sprite centre Y
//   state            out  1   0=QUEUE_INITIAL, 1=QUEUE_PLAYING
//   animation_state  out  1   facing: 0=QUEUE_LEFT, 1=QUEUE_RIGHT
//   airborne         out  1   1 while jump FSM not in GROUND
// BEHAVIOUR
//   Reset (rst_n=0 on clk edge): posX=START_X, posY=GROUND_Y, state=INITIAL, animation_state=RIGHT,
//     airborne=0, vy=0, jump FSM=GROUND, jump_pending=0, sync/edge flops cleared.
//   Buttons: 2-flop synchronizer each; start and jump are rising-edge detected on synced value.
//   Jump edge sets jump_pending (sticky) until consumed by the next frame_tick; cleared in INITIAL.
//   Game FSM: INITIAL -> PLAYING on start edge; PLAYING -> INITIAL when game_over=1 (priority over
//     all motion); entering INITIAL reloads spawn values as reset. In INITIAL outputs are held.
//   Transition wins over frame_tick in the same cycle: no motion applied on that tick.
//   All motion only in PLAYING on frame_tick; outputs registered, visible 1 clk after the tick.
//   Horizontal: left only -> posX-=SPEED_X, clamp >=X_MIN; right only -> +=SPEED_X, clamp <=X_MAX;
//     both or none -> no move. Facing follows the pressed direction; held when none/both.
//   Jump FSM GROUND/RISING/FALLING, vy signed 6-bit:
//     GROUND + jump_pending: vy=-JUMP_V, ->RISING, consume pending (posY moves on the next tick).
//     RISING/FALLING per tick: if posY+vy >= GROUND_Y -> posY=GROUND_Y, vy=0, ->GROUND;
//       elif posY+vy <= Y_MIN -> posY=Y_MIN, vy=0, ->FALLING; else posY+=vy,
//       vy=min(vy+GRAVITY, MAX_FALL); RISING->FALLING when new vy>=0.
//     jump_pending while airborne is discarded on that tick (no double jump, no buffering).
//   Arithmetic in 11-bit signed to avoid wrap; clamp before truncating to port width.
// STRUCTURE
//   Shared package: QUEUE_INITIAL/PLAYING, QUEUE_LEFT/RIGHT, jump FSM encodings, screen 640x480
//   constants (renderer uses the same state/facing codes).
//   One sub-module: btn_sync_edge (2-flop sync + rising-edge pulse), instantiated 4x (edge unused
//   for left/right).
// TESTING
//   Reset: rst_n=0 2 clks -> posX=100, posY=400, state=0, animation_state=1, airborne=0.
//   Start: pulse btn_start (hold 4 clks) -> state=1 ~3 clks later; posX/posY unchanged.
//   Walk: hold btn_left 10 ticks from 100 -> posX=80, facing=0; hold from 24 for 3 ticks -> 22 clamp.
//   Jump: jump edge, then ticks -> tick1 posY=388, tick12 322 (peak), tick25 400, airborne 0 on tick25.
//   Game over mid-jump at posY=350 with frame_tick same clk -> state=0, posX=100, posY=400, airborne=0.
//   Mid-op reset: rst_n=0 while RISING and left held -> all reset values next clk; no residual pending.

Source files
------------

// File: rtl/queue_motion_ctrl_pkg.sv
// Shared encodings and constants for the queue player sprite controller and its renderer.
package queue_motion_ctrl_pkg;

  typedef enum logic {
    QUEUE_INITIAL = 1'b0,
    QUEUE_PLAYING = 1'b1
  } game_state_e;

  typedef enum logic {
    QUEUE_LEFT  = 1'b0,
    QUEUE_RIGHT = 1'b1
  } facing_e;

  typedef enum logic [1:0] {
    JUMP_GROUND  = 2'd0,
    JUMP_RISING  = 2'd1,
    JUMP_FALLING = 2'd2
  } jump_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int POS_X_W = 10;
  localparam int POS_Y_W = 9;
  localparam int VY_W    = 6;
  // Wide enough that position +/- speed never wraps before clamping.
  localparam int ARITH_W = 11;

  // Clamp a signed working value into [lo, hi].
  function automatic logic signed [ARITH_W-1:0] clamp_s(
    input logic signed [ARITH_W-1:0] v,
    input logic signed [ARITH_W-1:0] lo,
    input logic signed [ARITH_W-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/queue_motion_ctrl_if.sv
// Button/frame inputs and sprite state outputs between the motion controller and the rest of the game.
interface queue_motion_ctrl_if;
  import queue_motion_ctrl_pkg::*;

  logic               frame_tick;
  logic               btn_start;
  logic               btn_left;
  logic               btn_right;
  logic               btn_jump;
  logic               game_over;
  logic [POS_X_W-1:0] posX;
  logic [POS_Y_W-1:0] posY;
  logic               state;
  logic               animation_state;
  logic               airborne;

  // Controller side.
  modport master (
    input  frame_tick, btn_start, btn_left, btn_right, btn_jump, game_over,
    output posX, posY, state, animation_state, airborne
  );

  // Game/renderer side.
  modport slave (
    output frame_tick, btn_start, btn_left, btn_right, btn_jump, game_over,
    input  posX, posY, state, animation_state, airborne
  );

endinterface

// File: rtl/queue_motion_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a rising-edge pulse on the synced level.
module queue_motion_ctrl_btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic level,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the raw button through the synchronizer and keep the previous synced value.
  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/queue_motion_ctrl.sv
// Per-frame motion and play-state sequencer for the queue player sprite.
module queue_motion_ctrl
  import queue_motion_ctrl_pkg::*;
#(
  parameter int START_X  = 100,
  parameter int GROUND_Y = 400,
  parameter int X_MIN    = 22,
  parameter int X_MAX    = 617,
  parameter int Y_MIN    = 25,
  parameter int SPEED_X  = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  queue_motion_ctrl_if.master bus
);

  localparam logic signed [ARITH_W-1:0] X_MIN_S    = ARITH_W'(X_MIN);
  localparam logic signed [ARITH_W-1:0] X_MAX_S    = ARITH_W'(X_MAX);
  localparam logic signed [ARITH_W-1:0] Y_MIN_S    = ARITH_W'(Y_MIN);
  localparam logic signed [ARITH_W-1:0] GROUND_Y_S = ARITH_W'(GROUND_Y);
  localparam logic signed [ARITH_W-1:0] SPEED_X_S  = ARITH_W'(SPEED_X);
  localparam logic signed [ARITH_W-1:0] GRAVITY_S  = ARITH_W'(GRAVITY);
  localparam logic signed [ARITH_W-1:0] MAX_FALL_S = ARITH_W'(MAX_FALL);
  localparam logic signed [VY_W-1:0]    JUMP_VY    = VY_W'(-JUMP_V);

  logic start_rise, jump_rise, left_lvl, right_lvl;
  logic start_level_unused, jump_level_unused, left_rise_unused, right_rise_unused;

  logic [POS_X_W-1:0]       pos_x_q, pos_x_d;
  logic [POS_Y_W-1:0]       pos_y_q, pos_y_d;
  logic signed [VY_W-1:0]   vy_q, vy_d;
  game_state_e              state_q, state_d;
  facing_e                  facing_q, facing_d;
  jump_state_e              jump_q, jump_d;
  logic                     jump_pending_q, jump_pending_d;

  logic                     jump_req;
  logic signed [ARITH_W-1:0] x_ext, y_ext, vy_ext, y_next, vy_next;

  queue_motion_ctrl_btn_sync_edge u_sync_start (
    .clk(clk), .rst_n(rst_n), .btn_async(bus.btn_start), .level(start_level_unused), .rise(start_rise)
  );
  queue_motion_ctrl_btn_sync_edge u_sync_left (
    .clk(clk), .rst_n(rst_n), .btn_async(bus.btn_left), .level(left_lvl), .rise(left_rise_unused)
  );
  queue_motion_ctrl_btn_sync_edge u_sync_right (
    .clk(clk), .rst_n(rst_n), .btn_async(bus.btn_right), .level(right_lvl), .rise(right_rise_unused)
  );
  queue_motion_ctrl_btn_sync_edge u_sync_jump (
    .clk(clk), .rst_n(rst_n), .btn_async(bus.btn_jump), .level(jump_level_unused), .rise(jump_rise)
  );

  // Next-state for game FSM, jump FSM, position, velocity and facing.
  always_comb begin
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    vy_d           = vy_q;
    state_d        = state_q;
    facing_d       = facing_q;
    jump_d         = jump_q;
    jump_pending_d = jump_pending_q | jump_rise;
    // An edge landing on the tick cycle itself still counts as a request.
    jump_req       = jump_pending_q | jump_rise;

    x_ext   = {{(ARITH_W-POS_X_W){1'b0}}, pos_x_q};
    y_ext   = {{(ARITH_W-POS_Y_W){1'b0}}, pos_y_q};
    vy_ext  = {{(ARITH_W-VY_W){vy_q[VY_W-1]}}, vy_q};
    y_next  = y_ext + vy_ext;
    vy_next = vy_ext + GRAVITY_S;
    if (vy_next > MAX_FALL_S) vy_next = MAX_FALL_S;

    case (state_q)
      QUEUE_INITIAL: begin
        jump_pending_d = 1'b0;
        if (start_rise) state_d = QUEUE_PLAYING;
      end
      default: begin
        if (bus.game_over) begin
          // Back to spawn; this wins over any motion on the same cycle.
          state_d        = QUEUE_INITIAL;
          pos_x_d        = POS_X_W'(START_X);
          pos_y_d        = POS_Y_W'(GROUND_Y);
          facing_d       = QUEUE_RIGHT;
          vy_d           = '0;
          jump_d         = JUMP_GROUND;
          jump_pending_d = 1'b0;
        end else if (bus.frame_tick) begin
          // Pending jump is consumed here, or discarded if already airborne.
          jump_pending_d = 1'b0;

          if (left_lvl && !right_lvl) begin
            pos_x_d  = POS_X_W'(clamp_s(x_ext - SPEED_X_S, X_MIN_S, X_MAX_S));
            facing_d = QUEUE_LEFT;
          end else if (right_lvl && !left_lvl) begin
            pos_x_d  = POS_X_W'(clamp_s(x_ext + SPEED_X_S, X_MIN_S, X_MAX_S));
            facing_d = QUEUE_RIGHT;
          end

          case (jump_q)
            JUMP_GROUND: begin
              if (jump_req) begin
                vy_d   = JUMP_VY;
                jump_d = JUMP_RISING;
              end
            end
            default: begin
              if (y_next >= GROUND_Y_S) begin
                pos_y_d = POS_Y_W'(GROUND_Y);
                vy_d    = '0;
                jump_d  = JUMP_GROUND;
              end else if (y_next <= Y_MIN_S) begin
                pos_y_d = POS_Y_W'(Y_MIN);
                vy_d    = '0;
                jump_d  = JUMP_FALLING;
              end else begin
                pos_y_d = y_next[POS_Y_W-1:0];
                vy_d    = vy_next[VY_W-1:0];
                if (jump_q == JUMP_RISING && !vy_next[ARITH_W-1]) jump_d = JUMP_FALLING;
              end
            end
          endcase
        end
      end
    endcase
  end

  // State, position and velocity registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x_q        <= POS_X_W'(START_X);
      pos_y_q        <= POS_Y_W'(GROUND_Y);
      vy_q           <= '0;
      state_q        <= QUEUE_INITIAL;
      facing_q       <= QUEUE_RIGHT;
      jump_q         <= JUMP_GROUND;
      jump_pending_q <= 1'b0;
    end else begin
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      vy_q           <= vy_d;
      state_q        <= state_d;
      facing_q       <= facing_d;
      jump_q         <= jump_d;
      jump_pending_q <= jump_pending_d;
    end
  end

  assign bus.posX            = pos_x_q;
  assign bus.posY            = pos_y_q;
  assign bus.state           = state_q;
  assign bus.animation_state = facing_q;
  assign bus.airborne        = (jump_q != JUMP_GROUND);

endmodule

// File: tb/tb_queue_motion_ctrl.sv
// Scoreboard bench for queue_motion_ctrl: a behavioural model predicts each frame's outputs.
module tb_queue_motion_ctrl;
  import queue_motion_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  queue_motion_ctrl_if bus();

  queue_motion_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  typedef struct {
    int x;
    int y;
    int st;
    int face;
    int air;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state.
  int m_x, m_y, m_st, m_face, m_air, m_vy;
  bit m_pend, m_left, m_right;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.x = m_x; e.y = m_y; e.st = m_st; e.face = m_face; e.air = m_air;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".posX"},  int'(bus.posX), e.x);
    chk({tag, ".posY"},  int'(bus.posY), e.y);
    chk({tag, ".state"}, int'(bus.state), e.st);
    chk({tag, ".face"},  int'(bus.animation_state), e.face);
    chk({tag, ".air"},   int'(bus.airborne), e.air);
  endtask

  task automatic model_spawn();
    m_x = 100; m_y = 400; m_st = 0; m_face = 1; m_air = 0; m_vy = 0; m_pend = 0;
  endtask

  task automatic model_tick();
    int ny;
    if (m_st == 1) begin
      if (m_left && !m_right) begin
        m_x = m_x - 2; if (m_x < 22) m_x = 22; m_face = 0;
      end else if (m_right && !m_left) begin
        m_x = m_x + 2; if (m_x > 617) m_x = 617; m_face = 1;
      end
      if (m_air == 0) begin
        if (m_pend) begin m_vy = -12; m_air = 1; end
      end else begin
        ny = m_y + m_vy;
        if (ny >= 400) begin m_y = 400; m_vy = 0; m_air = 0; end
        else if (ny <= 25) begin m_y = 25; m_vy = 0; end
        else begin m_y = ny; m_vy = m_vy + 1; if (m_vy > 12) m_vy = 12; end
      end
      m_pend = 0;
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    model_tick();
    push_exp();
    @(negedge clk);
    bus.frame_tick = 1'b0;
    pop_check(tag);
  endtask

  task automatic set_btns(input bit l, input bit r);
    @(negedge clk);
    bus.btn_left = l; bus.btn_right = r;
    m_left = l; m_right = r;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.btn_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("start_latency.state", int'(bus.state), 0);
    m_st = 1;
    push_exp();
    @(negedge clk);
    pop_check("start");
    @(negedge clk);
    bus.btn_start = 1'b0;
  endtask

  task automatic pulse_jump();
    @(negedge clk);
    bus.btn_jump = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_jump = 1'b0;
    if (m_st == 1) m_pend = 1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    bus.frame_tick = 1'b0; bus.btn_start = 1'b0; bus.btn_left = 1'b0;
    bus.btn_right = 1'b0; bus.btn_jump = 1'b0; bus.game_over = 1'b0;
    m_left = 0; m_right = 0;
    model_spawn();

    // Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    pop_check("reset");

    // Held in INITIAL even with a direction and a tick
    set_btns(1, 0);
    tick("init_hold");

    // Start, then walking and clamps
    pulse_start();
    for (int i = 0; i < 10; i++) tick("walk_left");
    chk("walk_left.x80", int'(bus.posX), 80);
    chk("walk_left.face", int'(bus.animation_state), 0);
    set_btns(0, 1);
    for (int i = 0; i < 3; i++) tick("walk_right");
    set_btns(1, 0);
    tick("turn_left");
    set_btns(1, 1);
    for (int i = 0; i < 2; i++) tick("both");
    chk("both.face_held", int'(bus.animation_state), 0);
    set_btns(0, 0);
    tick("none");
    set_btns(1, 0);
    for (int i = 0; i < 30; i++) tick("to_left_edge");
    chk("left_edge.x24", int'(bus.posX), 24);
    for (int i = 0; i < 3; i++) tick("clamp_left");
    chk("clamp_left.x22", int'(bus.posX), 22);
    set_btns(0, 1);
    for (int i = 0; i < 300; i++) tick("to_right_edge");
    chk("clamp_right.x617", int'(bus.posX), 617);
    set_btns(0, 0);

    // Full jump arc
    pulse_jump();
    tick("launch");
    chk("launch.y_unmoved", int'(bus.posY), 400);
    for (int t = 1; t <= 25; t++) begin
      tick("jump_arc");
      if (t == 1) chk("jump.tick1_y", int'(bus.posY), 388);
      if (t == 12) chk("jump.tick12_y", int'(bus.posY), 322);
      if (t == 25) begin
        chk("jump.tick25_y", int'(bus.posY), 400);
        chk("jump.tick25_air", int'(bus.airborne), 0);
      end
    end

    // Double-jump attempt is ignored, then game over mid-jump with a tick
    pulse_jump();
    tick("launch2");
    for (int t = 1; t <= 5; t++) begin
      tick("rise2");
      if (t == 2) pulse_jump();
    end
    chk("pre_gameover.y350", int'(bus.posY), 350);
    @(negedge clk);
    bus.game_over = 1'b1; bus.frame_tick = 1'b1;
    model_spawn();
    push_exp();
    @(negedge clk);
    bus.game_over = 1'b0; bus.frame_tick = 1'b0;
    pop_check("gameover");

    // Mid-operation reset while rising with left held
    pulse_start();
    set_btns(1, 0);
    pulse_jump();
    tick("launch3");
    tick("rise3");
    pulse_jump();
    @(negedge clk);
    rst_n = 1'b0;
    model_spawn();
    push_exp();
    @(negedge clk);
    rst_n = 1'b1;
    pop_check("midop_reset");
    set_btns(0, 0);
    pulse_start();
    tick("post_reset");
    tick("post_reset2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
